// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird game controller.
package flappy_pkg;

    // Round phases; the numeric values are visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } game_state_t;

    // Default playfield geometry in pixels.
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_BIRD_X   = 100;
    localparam int DEF_BIRD_W   = 40;
    localparam int DEF_BIRD_H   = 40;
    localparam int DEF_PIPE_W   = 40;
    localparam int DEF_GAP_H    = 120;

    // Gap placement: the top edge is GAP_MIN plus the 8-bit random value.
    localparam logic [9:0] GAP_MIN       = 10'd40;
    localparam logic [9:0] GAP_TOP_RESET = 10'd180;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, feedback from bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // One shift of the gap LFSR; a non-zero seed never reaches zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button level, followed by a
// registered rising-edge detector. rise pulses one cycle, three cycles
// after the input edge.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic level_d;

    // Synchronize the level, keep its previous value, and register the edge.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_1  <= in;
            sync_2  <= sync_1;
            level_d <= sync_2;
            rise    <= sync_2 & ~level_d;
        end
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game controller: round sequencing (IDLE/RUN/DEAD), game
// tick generation, pipe scroll and gap placement, collision and scoring.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int TICK_DIV  = 500000,
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int BIRD_X    = DEF_BIRD_X,
    parameter int BIRD_W    = DEF_BIRD_W,
    parameter int BIRD_H    = DEF_BIRD_H,
    parameter int PIPE_W    = DEF_PIPE_W,
    parameter int GAP_H     = DEF_GAP_H,
    parameter int DEAD_HOLD = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pressed,
    input  logic [9:0] bird_y,
    output logic       tick,
    output logic       bird_run,
    output logic       bird_rst,
    output logic       flap,
    output logic [9:0] pipe_x,
    output logic [9:0] gap_top,
    output logic [9:0] gap_bot,
    output logic [7:0] score,
    output logic [1:0] state
);

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0] TICK_PRE  = 32'(TICK_DIV - 2);

    localparam logic [9:0] SCREEN_W_V = 10'(SCREEN_W);
    localparam logic [9:0] GAP_H_V    = 10'(GAP_H);
    // The pipe has fully cleared the bird when it leaves this x position.
    localparam logic [9:0] SCORE_X    = 10'(BIRD_X - PIPE_W);

    // Collision math runs one bit wider so the sums cannot wrap.
    localparam logic [10:0] BIRD_X_W   = 11'(BIRD_X);
    localparam logic [10:0] BIRD_R_W   = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0] BIRD_H_W   = 11'(BIRD_H);
    localparam logic [10:0] PIPE_W_W   = 11'(PIPE_W);
    localparam logic [10:0] SCREEN_H_W = 11'(SCREEN_H);

    localparam int                DC_W        = $clog2(DEAD_HOLD + 1);
    localparam logic [DC_W-1:0]   DEAD_HOLD_V = DC_W'(DEAD_HOLD);

    logic            btn_rise;
    logic [31:0]     tick_cnt;

    game_state_t     state_q;
    game_state_t     state_d;
    logic [9:0]      pipe_x_d;
    logic [9:0]      gap_top_d;
    logic [9:0]      gap_bot_d;
    logic [7:0]      score_d;
    logic [7:0]      lfsr_q;
    logic [7:0]      lfsr_d;
    logic [DC_W-1:0] dead_cnt_q;
    logic [DC_W-1:0] dead_cnt_d;
    logic            bird_rst_d;
    logic            flap_d;

    logic [10:0]     px_w;
    logic [10:0]     by_w;
    logic [10:0]     gt_w;
    logic [10:0]     gb_w;
    logic            h_overlap;
    logic            v_miss;
    logic            out_of_bounds;
    logic            hit;

    btn_sync_edge u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (btn_pressed),
        .rise  (btn_rise)
    );

    // Free-running tick divider; tick is high while the count sits at TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 32'd1;
            end
            tick <= (tick_cnt == TICK_PRE);
        end
    end

    assign px_w = {1'b0, pipe_x};
    assign by_w = {1'b0, bird_y};
    assign gt_w = {1'b0, gap_top};
    assign gb_w = {1'b0, gap_bot};

    // Bird box against the pipe columns and the screen edges (bird_y is its bottom).
    always_comb begin
        h_overlap     = (px_w < BIRD_R_W) && ((px_w + PIPE_W_W) > BIRD_X_W);
        v_miss        = (by_w < (BIRD_H_W + gt_w)) || (by_w > gb_w);
        out_of_bounds = (by_w < BIRD_H_W) || (by_w >= SCREEN_H_W);
        hit           = (h_overlap && v_miss) || out_of_bounds;
    end

    // Round sequencing and per-tick game update from pre-tick register values.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        pipe_x_d   = pipe_x;
        gap_top_d  = gap_top;
        gap_bot_d  = gap_bot;
        score_d    = score;
        lfsr_d     = lfsr_q;
        dead_cnt_d = dead_cnt_q;
        bird_rst_d = 1'b0;
        flap_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A tick coinciding with the start press has nothing to act on here.
                if (btn_rise) begin
                    state_d    = ST_RUN;
                    bird_rst_d = 1'b1;
                    pipe_x_d   = SCREEN_W_V;
                    score_d    = 8'd0;
                    dead_cnt_d = '0;
                end
            end

            ST_RUN: begin
                flap_d = btn_rise;
                if (tick) begin
                    if (hit) begin
                        // The fatal tick leaves the pipe and score where they were.
                        state_d = ST_DEAD;
                    end else if (pipe_x == 10'd0) begin
                        lfsr_d    = lfsr_step(lfsr_q);
                        gap_top_d = GAP_MIN + {2'b00, lfsr_d};
                        gap_bot_d = gap_top_d + GAP_H_V;
                        pipe_x_d  = SCREEN_W_V;
                    end else begin
                        pipe_x_d = pipe_x - 10'd1;
                        if ((pipe_x == SCORE_X) && (score != 8'hFF)) begin
                            score_d = score + 8'd1;
                        end
                    end
                end
            end

            ST_DEAD: begin
                if (btn_rise && (dead_cnt_q >= DEAD_HOLD_V)) begin
                    state_d = ST_IDLE;
                end
                if (tick && (dead_cnt_q < DEAD_HOLD_V)) begin
                    dead_cnt_d = dead_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Game state and all controller outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pipe_x     <= SCREEN_W_V;
            gap_top    <= GAP_TOP_RESET;
            gap_bot    <= GAP_TOP_RESET + GAP_H_V;
            score      <= 8'd0;
            lfsr_q     <= LFSR_SEED;
            dead_cnt_q <= '0;
            bird_run   <= 1'b0;
            bird_rst   <= 1'b0;
            flap       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pipe_x     <= pipe_x_d;
            gap_top    <= gap_top_d;
            gap_bot    <= gap_bot_d;
            score      <= score_d;
            lfsr_q     <= lfsr_d;
            dead_cnt_q <= dead_cnt_d;
            bird_run   <= (state_d == ST_RUN);
            bird_rst   <= bird_rst_d;
            flap       <= flap_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl with TICK_DIV=4, DEAD_HOLD=3.
module tb_flappy_game_ctrl;
    import flappy_pkg::*;

    localparam int TD = 4;
    localparam int DH = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_pressed = 1'b0;
    logic [9:0] bird_y = 10'd260;
    logic       tick, bird_run, bird_rst, flap;
    logic [9:0] pipe_x, gap_top, gap_bot;
    logic [7:0] score;
    logic [1:0] state;

    always #5 clk = ~clk;

    flappy_game_ctrl #(.TICK_DIV(TD), .DEAD_HOLD(DH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_pressed (btn_pressed),
        .bird_y      (bird_y),
        .tick        (tick),
        .bird_run    (bird_run),
        .bird_rst    (bird_rst),
        .flap        (flap),
        .pipe_x      (pipe_x),
        .gap_top     (gap_top),
        .gap_bot     (gap_bot),
        .score       (score),
        .state       (state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model (game rules, tick granularity) ----------------
    int m_state, m_px, m_gt, m_gb, m_score, m_lfsr, m_dead, m_cyc;
    bit m_flap, m_brst, m_run;
    bit hist [4];   // button samples, hist[0] newest

    function automatic int lfsr_ref(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) & 255) | fb;
    endfunction

    task automatic model_reset();
        m_state = 0; m_px = 640; m_gt = 180; m_gb = 300; m_score = 0;
        m_lfsr = 'hA5; m_dead = 0; m_cyc = 0;
        m_flap = 0; m_brst = 0; m_run = 0;
        for (int i = 0; i < 4; i++) hist[i] = 0;
    endtask

    task automatic model_step();
        bit tick_now, rise_now, go_idle, hit;
        int by;
        by       = int'(bird_y);
        tick_now = (m_cyc % TD) == TD - 1;
        // the press edge appears as a pulse three samples after it is seen
        rise_now = hist[2] && !hist[3];
        m_flap   = (m_state == 1) && rise_now;
        m_brst   = (m_state == 0) && rise_now;
        case (m_state)
            0: if (rise_now) begin
                m_state = 1; m_px = 640; m_score = 0; m_dead = 0;
            end
            1: if (tick_now) begin
                hit = ((m_px < 100 + 40) && (m_px + 40 > 100) && (by < 40 + m_gt || by > m_gb))
                      || by < 40 || by >= 480;
                if (hit) m_state = 2;
                else if (m_px == 0) begin
                    m_lfsr = lfsr_ref(m_lfsr);
                    m_gt = 40 + m_lfsr; m_gb = m_gt + 120; m_px = 640;
                end else begin
                    if (m_px == 60 && m_score < 255) m_score++;
                    m_px--;
                end
            end
            default: begin
                go_idle = rise_now && m_dead >= DH;
                if (tick_now && m_dead < DH) m_dead++;
                if (go_idle) m_state = 0;
            end
        endcase
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = btn_pressed;
        m_cyc++;
        m_run = (m_state == 1);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic compare_model();
        check("rnd_state",    state,    m_state);
        check("rnd_pipe_x",   pipe_x,   m_px);
        check("rnd_gap_top",  gap_top,  m_gt);
        check("rnd_gap_bot",  gap_bot,  m_gb);
        check("rnd_score",    score,    m_score);
        check("rnd_tick",     tick,     ((m_cyc % TD) == TD - 1) ? 1 : 0);
        check("rnd_bird_run", bird_run, m_run);
        check("rnd_bird_rst", bird_rst, m_brst);
        check("rnd_flap",     flap,     m_flap);
    endtask

    // ---------------- directed helpers ----------------
    task automatic wait_px(input int target, input int budget, input string name);
        int k = 0;
        while (pipe_x !== 10'(target) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, pipe_x, target);
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int k = 0;
        while (state !== 2'(target) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, state, target);
    endtask

    typedef struct {
        logic       btn;
        logic [9:0] by;
        logic       tick;
        logic [1:0] st;
        logic       brst;
        logic       run;
        logic       flap;
        logic [9:0] px;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic btn, input logic tk, input logic [1:0] st,
                           input logic brst, input logic run, input logic fl, input logic [9:0] px);
        vec_t v;
        v.btn = btn; v.by = 10'd260; v.tick = tk; v.st = st;
        v.brst = brst; v.run = run; v.flap = fl; v.px = px;
        vecs.push_back(v);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Row i: inputs before clock edge i+1, outputs expected after it.
        // Press seen at edge 1 -> pulse after edge 3 (same cycle as first tick)
        // -> RUN after edge 4; second press at edge 9 -> flap after edge 12.
        //       btn tick st brst run flap px
        add_vec(1, 0, 0, 0, 0, 0, 640);
        add_vec(1, 0, 0, 0, 0, 0, 640);
        add_vec(1, 1, 0, 0, 0, 0, 640);
        add_vec(1, 0, 1, 1, 1, 0, 640);
        add_vec(1, 0, 1, 0, 1, 0, 640);
        add_vec(1, 0, 1, 0, 1, 0, 640);
        add_vec(0, 1, 1, 0, 1, 0, 640);
        add_vec(0, 0, 1, 0, 1, 0, 639);
        add_vec(1, 0, 1, 0, 1, 0, 639);
        add_vec(1, 0, 1, 0, 1, 0, 639);
        add_vec(1, 1, 1, 0, 1, 0, 639);
        add_vec(1, 0, 1, 0, 1, 1, 638);
        add_vec(1, 0, 1, 0, 1, 0, 638);

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("rst_state",    state,    0);
        check("rst_pipe_x",   pipe_x,   640);
        check("rst_gap_top",  gap_top,  180);
        check("rst_gap_bot",  gap_bot,  300);
        check("rst_score",    score,    0);
        check("rst_tick",     tick,     0);
        check("rst_bird_run", bird_run, 0);
        check("rst_bird_rst", bird_rst, 0);
        check("rst_flap",     flap,     0);
        rst_n = 1'b1;

        // Tick cadence, start of round, flap pulse.
        foreach (vecs[i]) begin
            btn_pressed = vecs[i].btn;
            bird_y      = vecs[i].by;
            @(negedge clk);
            check($sformatf("vec%0d_tick", i),     tick,     vecs[i].tick);
            check($sformatf("vec%0d_state", i),    state,    vecs[i].st);
            check($sformatf("vec%0d_bird_rst", i), bird_rst, vecs[i].brst);
            check($sformatf("vec%0d_bird_run", i), bird_run, vecs[i].run);
            check($sformatf("vec%0d_flap", i),     flap,     vecs[i].flap);
            check($sformatf("vec%0d_pipe_x", i),   pipe_x,   vecs[i].px);
            check($sformatf("vec%0d_score", i),    score,    0);
        end
        btn_pressed = 1'b0;

        // Score on leaving x=60, then wrap with the first LFSR gap.
        wait_px(60, 3000, "reach_px_60");
        check("score_before_60", score, 0);
        wait_px(59, 8, "reach_px_59");
        check("score_after_60", score, 1);
        wait_px(0, 400, "reach_px_0");
        wait_px(640, 8, "wrap_px_640");
        // 0xA5 shifts to 0x4A (74): gap 114..234
        check("wrap_gap_top", gap_top, 114);
        check("wrap_gap_bot", gap_bot, 234);
        check("wrap_gap_height", 32'(gap_bot) - 32'(gap_top), 120);
        check("wrap_score", score, 1);
        check("wrap_state", state, 1);
        bird_y = 10'd200;

        // Pipe collision at x=120.
        wait_px(120, 3000, "reach_px_120");
        bird_y = 10'd150;
        wait_state(2, 8, "collide_dead");
        check("collide_px_frozen", pipe_x, 120);
        check("collide_score", score, 1);
        check("collide_bird_run", bird_run, 0);

        // Dead hold: early press ignored, late press returns to IDLE.
        btn_pressed = 1'b1;
        repeat (8) @(negedge clk);
        check("dead_hold_early", state, 2);
        btn_pressed = 1'b0;
        repeat (16) @(negedge clk);
        btn_pressed = 1'b1;
        wait_state(0, 8, "dead_exit_idle");
        check("dead_exit_bird_run", bird_run, 0);

        // Screen-bound death on the first tick of a round.
        btn_pressed = 1'b0;
        bird_y = 10'd30;
        repeat (4) @(negedge clk);
        btn_pressed = 1'b1;
        wait_state(1, 8, "bounds_start_run");
        check("bounds_start_px", pipe_x, 640);
        check("bounds_start_score", score, 0);
        wait_state(2, 8, "bounds_dead");
        check("bounds_px_frozen", pipe_x, 640);
        btn_pressed = 1'b0;
        repeat (16) @(negedge clk);
        btn_pressed = 1'b1;
        wait_state(0, 8, "bounds_exit_idle");
        btn_pressed = 1'b0;

        // Fly through five pipes, then reset asynchronously mid-round.
        bird_y = gap_bot - 10'd10;
        repeat (4) @(negedge clk);
        btn_pressed = 1'b1;
        wait_state(1, 8, "five_start_run");
        btn_pressed = 1'b0;
        for (int k = 0; k < 14000 && score !== 8'd5; k++) begin
            bird_y = gap_bot - 10'd10;
            @(negedge clk);
        end
        check("five_score", score, 5);
        check("five_state", state, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_score",  score,    0);
        check("async_rst_state",  state,    0);
        check("async_rst_pipe_x", pipe_x,   640);
        check("async_rst_run",    bird_run, 0);
        @(negedge clk);
        bird_y = 10'd260;
        rst_n = 1'b1;

        // Randomized play against the reference model.
        for (int c = 0; c < 16000 && n_fail < 20; c++) begin
            @(negedge clk);
            compare_model();
            if ($urandom_range(0, 19) == 0) btn_pressed = ~btn_pressed;
            if (c % 32 == 0) begin
                case ($urandom_range(0, 9))
                    9:       bird_y = 10'($urandom_range(0, 1023));
                    8:       bird_y = 10'($urandom_range(40, 479));
                    default: bird_y = 10'(m_gb - int'($urandom_range(0, 80)));
                endcase
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
